// File: rtl/eq_share_arbiter.sv
// Round-robin arbiter that time-shares one external combinational equality
// comparator among N_REQ requesters and returns each match result with a done pulse.
module eq_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int W       = 8,
    parameter int CMP_LAT = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] a_in,
    input  logic [N_REQ*W-1:0] b_in,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   done,
    output logic               eq_out,
    output logic               busy,
    output logic [W-1:0]       cmp_a,
    output logic [W-1:0]       cmp_b,
    input  logic               cmp_eq,
    output logic [15:0]        cmp_count
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               eq_q, eq_d;
    logic [W-1:0]       cmp_a_q, cmp_a_d;
    logic [W-1:0]       cmp_b_q, cmp_b_d;
    logic [15:0]        count_q, count_d;
    logic [CW-1:0]      wait_q, wait_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic               pick_valid;
    logic [IW-1:0]      pick_idx;

    // Modular (base + off) over 0..N_REQ-1, valid for any N_REQ, not only powers of two.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_REQ) sum = sum - N_REQ;
        return IW'(sum);
    endfunction

    // Walk offsets downward so the smallest offset from rr_q is the one left standing.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            if (req[wrap_add(rr_q, off)]) begin
                pick_valid = 1'b1;
                pick_idx   = wrap_add(rr_q, off);
            end
        end
    end

    always_comb begin
        // NOTE: every next-state variable takes its held value first, so no path leaves one unassigned and no latch is inferred.
        state_d = state_q;
        grant_d = grant_q;
        done_d  = done_q;
        eq_d    = eq_q;
        cmp_a_d = cmp_a_q;
        cmp_b_d = cmp_b_q;
        count_d = count_q;
        wait_d  = wait_q;
        rr_d    = rr_q;
        owner_d = owner_q;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d           = DRIVE;
                    owner_d           = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    cmp_a_d           = a_in[int'(pick_idx) * W +: W];
                    cmp_b_d           = b_in[int'(pick_idx) * W +: W];
                    wait_d            = CW'(CMP_LAT - 1);
                end
            end
            DRIVE: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - 1'b1;
                end else begin
                    state_d = RESP;
                    eq_d    = cmp_eq;
                    done_d  = grant_q;
                    count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                    rr_d    = wrap_add(owner_q, 1);
                end
            end
            RESP: begin
                state_d = IDLE;
                done_d  = '0;
                grant_d = '0;
                eq_d    = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            eq_q    <= 1'b0;
            cmp_a_q <= '0;
            cmp_b_q <= '0;
            count_q <= '0;
            wait_q  <= '0;
            rr_q    <= '0;
            owner_q <= '0;
        end else begin
            // NOTE: non-blocking updates so every register sees pre-edge values of the others.
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            eq_q    <= eq_d;
            cmp_a_q <= cmp_a_d;
            cmp_b_q <= cmp_b_d;
            count_q <= count_d;
            wait_q  <= wait_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign eq_out    = eq_q;
    assign busy      = (state_q != IDLE);
    assign cmp_a     = cmp_a_q;
    assign cmp_b     = cmp_b_q;
    assign cmp_count = count_q;

endmodule

// File: tb/tb_eq_share_arbiter.sv
// Bench for eq_share_arbiter: two instances (CMP_LAT=1 and 4) share stimulus and are
// compared every cycle against a transaction-level model driven by grant timestamps.
module tb_eq_share_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] a_in, b_in;

    logic [N-1:0] grant1, done1, grant4, done4;
    logic         eq1, busy1, eq4, busy4, cmp_eq1, cmp_eq4;
    logic [W-1:0] cmpa1, cmpb1, cmpa4, cmpb4;
    logic [15:0]  cnt1, cnt4;

    int checks   = 0;
    int failures = 0;
    int n        = 0;

    // Transaction-level reference state, index 0 = CMP_LAT 1, index 1 = CMP_LAT 4.
    int          m_owner[2];
    int          m_g[2];
    int          m_rr[2];
    logic [15:0] m_cnt[2];
    logic [7:0]  m_a[2], m_b[2];
    logic        m_eq[2], m_dn[2];

    always #5 clk = ~clk;

    // External comparators
    assign cmp_eq1 = (cmpa1 == cmpb1);
    assign cmp_eq4 = (cmpa4 == cmpb4);

    eq_share_arbiter #(.N_REQ(N), .W(W), .CMP_LAT(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .req(req), .a_in(a_in), .b_in(b_in),
        .grant(grant1), .done(done1), .eq_out(eq1), .busy(busy1),
        .cmp_a(cmpa1), .cmp_b(cmpb1), .cmp_eq(cmp_eq1), .cmp_count(cnt1)
    );

    eq_share_arbiter #(.N_REQ(N), .W(W), .CMP_LAT(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .req(req), .a_in(a_in), .b_in(b_in),
        .grant(grant4), .done(done4), .eq_out(eq4), .busy(busy4),
        .cmp_a(cmpa4), .cmp_b(cmpb4), .cmp_eq(cmp_eq4), .cmp_count(cnt4)
    );

    function automatic int lat_of(int d);
        return (d == 0) ? 1 : 4;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = -1;
            m_g[d]     = 0;
            m_rr[d]    = 0;
            m_cnt[d]   = 16'd0;
            m_a[d]     = 8'd0;
            m_b[d]     = 8'd0;
            m_eq[d]    = 1'b0;
            m_dn[d]    = 1'b0;
        end
    endtask

    // One clock edge of the model, using the inputs as they stood at that edge.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            if (m_owner[d] >= 0) begin
                if (n == m_g[d] + lat_of(d) + 1) begin
                    m_owner[d] = -1;
                    m_dn[d]    = 1'b0;
                    m_eq[d]    = 1'b0;
                end else if (n == m_g[d] + lat_of(d)) begin
                    m_dn[d] = 1'b1;
                    m_eq[d] = (m_a[d] == m_b[d]);
                    if (m_cnt[d] != 16'hFFFF) m_cnt[d] = m_cnt[d] + 16'd1;
                    m_rr[d] = (m_owner[d] + 1) % N;
                end
            end else if (req != '0) begin
                bit found;
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (m_rr[d] + k) % N;
                    if (!found && req[i]) begin
                        found      = 1'b1;
                        m_owner[d] = i;
                        m_g[d]     = n;
                        m_a[d]     = a_in[i*W +: W];
                        m_b[d]     = b_in[i*W +: W];
                    end
                end
            end
        end
    endtask

    function automatic logic [31:0] e_grant(int d);
        return (m_owner[d] >= 0) ? (32'd1 << m_owner[d]) : 32'd0;
    endfunction

    function automatic logic [31:0] e_done(int d);
        return (m_owner[d] >= 0 && m_dn[d]) ? (32'd1 << m_owner[d]) : 32'd0;
    endfunction

    task automatic check_all();
        check("d1.grant",     32'(grant1), e_grant(0));
        check("d1.done",      32'(done1),  e_done(0));
        check("d1.eq_out",    32'(eq1),    32'(m_eq[0]));
        check("d1.busy",      32'(busy1),  32'(m_owner[0] >= 0));
        check("d1.cmp_a",     32'(cmpa1),  32'(m_a[0]));
        check("d1.cmp_b",     32'(cmpb1),  32'(m_b[0]));
        check("d1.cmp_count", 32'(cnt1),   32'(m_cnt[0]));
        check("d4.grant",     32'(grant4), e_grant(1));
        check("d4.done",      32'(done4),  e_done(1));
        check("d4.eq_out",    32'(eq4),    32'(m_eq[1]));
        check("d4.busy",      32'(busy4),  32'(m_owner[1] >= 0));
        check("d4.cmp_a",     32'(cmpa4),  32'(m_a[1]));
        check("d4.cmp_b",     32'(cmpb4),  32'(m_b[1]));
        check("d4.cmp_count", 32'(cnt4),   32'(m_cnt[1]));
    endtask

    // Advance one edge, update the model, then sample outputs 1 time unit later.
    task automatic step();
        @(posedge clk);
        n++;
        if (reset_n) model_edge();
        #1;
        check_all();
    endtask

    // Asynchronous reset asserted mid-cycle, held across one edge, released after it.
    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        a_in    = '0;
        b_in    = '0;
        model_reset();
        #1;
        check_all();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        int bcnt;
        reset_n = 1'b0;
        req     = '0;
        a_in    = '0;
        b_in    = '0;
        model_reset();
        #2;
        do_reset();

        // Single request, equal operands
        req = 4'b0001;
        step();
        check("s1.grant", 32'(grant1), 32'h1);
        check("s1.cmp_a", 32'(cmpa1), 32'h00);
        step();
        check("s1.done", 32'(done1), 32'h1);
        check("s1.eq_out", 32'(eq1), 32'h1);
        req = '0;
        step();
        check("s1.done_clr", 32'(done1), 32'h0);
        check("s1.count", 32'(cnt1), 32'h1);
        repeat (4) step();

        // Mismatch, operand change after grant is ignored
        do_reset();
        req = 4'b0100;
        a_in[2*W +: W] = 8'h18;
        b_in[2*W +: W] = 8'h60;
        step();
        check("s2.grant", 32'(grant1), 32'h4);
        a_in[2*W +: W] = 8'h60;
        step();
        check("s2.done", 32'(done1), 32'h4);
        check("s2.eq_out", 32'(eq1), 32'h0);
        req = '0;
        repeat (5) step();

        // Contention: all requesting, all operand pairs equal
        do_reset();
        req  = 4'b1111;
        a_in = $urandom();
        b_in = a_in;
        for (int e = 0; e < 15; e++) begin
            step();
            if (e % 3 == 0) check("s3.grant_order", 32'(grant1), 32'd1 << ((e / 3) % 4));
            if (e % 3 == 1) check("s3.done_order", 32'(done1), 32'd1 << ((e / 3) % 4));
        end
        req = '0;
        repeat (6) step();

        // Fairness: requester 3 arrives while requester 1 is in DRIVE
        do_reset();
        req = 4'b0010;
        step();
        req = 4'b1010;
        step();
        step();
        step();
        check("s4.grant_r3", 32'(grant1), 32'h8);
        step();
        step();
        step();
        check("s4.grant_r1", 32'(grant1), 32'h2);
        req = '0;
        repeat (8) step();

        // Four-cycle settling on the CMP_LAT=4 instance
        do_reset();
        req = 4'b0010;
        a_in[1*W +: W] = 8'hC0;
        b_in[1*W +: W] = 8'h65;
        bcnt = 0;
        for (int e = 0; e < 7; e++) begin
            step();
            if (e == 0) check("s5.grant", 32'(grant4), 32'h2);
            if (busy4) bcnt++;
            check("s5.done_timing", 32'(done4), (e == 4) ? 32'h2 : 32'h0);
            if (e == 4) begin
                check("s5.eq_out", 32'(eq4), 32'h0);
                req = '0;
            end
        end
        check("s5.busy_cycles", 32'(bcnt), 32'd5);
        repeat (4) step();

        // Reset two edges after the grant aborts the compare
        do_reset();
        req = 4'b0010;
        a_in[1*W +: W] = 8'h33;
        b_in[1*W +: W] = 8'h33;
        step();
        req = '0;
        step();
        step();
        #2;
        do_reset();
        check("s6.busy", 32'(busy4), 32'h0);
        check("s6.grant", 32'(grant4), 32'h0);
        repeat (6) step();
        check("s6.count", 32'(cnt4), 32'h0);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            req = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                logic [7:0] av;
                av = 8'($urandom());
                a_in[i*W +: W] = av;
                b_in[i*W +: W] = ($urandom_range(0, 1) == 1) ? av : 8'($urandom());
            end
            step();
        end
        req = '0;
        repeat (8) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
